ucsbece154a_mem_responder: RTL and testbench

- Unified instruction/data memory that serves the multicycle core's single memory port.
- Accepts one word read or write request at a time over a req/ready handshake.
- Inserts a parameterised number of wait states, then returns read data or commits write data.
- Flags misaligned or out-of-range accesses with an error response.
- Sits between the datapath's address mux (PC or ALUResult) and the backing storage array.

---
 rtl/ucsbece154a_mem_responder.sv | 122 ++++++++++++
 tb/tb_ucsbece154a_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_mem_responder.sv
// ucsbece154a_mem_responder: unified instruction/data memory behind the
// multicycle core's single memory port. Each request is accepted over a
// req/ready handshake, held for LATENCY wait states, then answered with
// read data, a write commit, or an error response for bad addresses.
module ucsbece154a_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] a_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd_o,
   output logic        ready_o,
   output logic        err_o
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT4     = 4'(LATENCY);
   localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);
   localparam bit          LAT_ZERO = (LATENCY == 0);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [31:0] a_q;
   logic [31:0] wd_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             acc_we;
   logic [31:0]      acc_a;
   logic [31:0]      acc_wd;
   logic [31:0]      off;
   logic [IDX_W-1:0] idx;
   logic             acc_err;
   logic             enter_resp;

   // Select the request being answered at this edge and decode its address.
   // With zero latency the accept edge is also the edge entering RESP, so the
   // live inputs stand in for the not-yet-loaded request registers.
   always_comb begin
      acc_we     = we_q;
      acc_a      = a_q;
      acc_wd     = wd_q;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req_i && LAT_ZERO) begin
               enter_resp = 1'b1;
               acc_we     = we_i;
               acc_a      = a_i;
               acc_wd     = wd_i;
            end
         end
         WAIT:    enter_resp = (cnt == 4'd1);
         default: enter_resp = 1'b0;
      endcase
      // BASE_ADDR is word aligned, so off[1:0] equals the address's low bits.
      off     = acc_a - BASE_ADDR;
      idx     = off[IDX_W+1:2];
      acc_err = (off[1:0] != 2'b00) || (acc_a < BASE_ADDR) ||
                ({2'b00, off[31:2]} >= DEPTH32);
   end

   // Request sequencing plus registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ready_o <= 1'b0;
         err_o   <= 1'b0;
         rd_o    <= '0;
      end else begin
         ready_o <= 1'b0;
         err_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  we_q  <= we_i;
                  a_q   <= a_i;
                  wd_q  <= wd_i;
                  cnt   <= LAT4;
                  state <= LAT_ZERO ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            ready_o <= 1'b1;
            err_o   <= acc_err;
            if (!acc_we) begin
               rd_o <= acc_err ? '0 : mem[idx];
            end
         end
      end
   end

   // Storage array commit; never reset, and a reset edge aborts the commit.
   always_ff @(posedge clk) begin
      if (!reset && enter_resp && acc_we && !acc_err) begin
         mem[idx] <= acc_wd;
      end
   end

endmodule

// File: tb/tb_ucsbece154a_mem_responder.sv
// Bench for ucsbece154a_mem_responder: a transaction-level model of the
// memory checked every cycle against the LATENCY=2 instance, literal
// expectations for the directed scenarios, and a LATENCY=0 instance driven
// with req held high.
module tb_ucsbece154a_mem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned IW    = $clog2(DEPTH);
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int unsigned LAT   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req, we;
   logic [31:0] a, wd, rd;
   logic        ready, err;
   logic        req0, we0;
   logic [31:0] a0, wd0, rd0;
   logic        ready0, err0;

   ucsbece154a_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req_i(req), .we_i(we), .a_i(a), .wd_i(wd),
      .rd_o(rd), .ready_o(ready), .err_o(err)
   );

   ucsbece154a_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .req_i(req0), .we_i(we0), .a_i(a0), .wd_i(wd0),
      .rd_o(rd0), .ready_o(ready0), .err_o(err0)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] mm [DEPTH];
   int unsigned e = 0, free_edge = 0, resp_edge = 0;
   bit          pend = 1'b0, live = 1'b0;
   logic        p_we;
   logic [31:0] p_a, p_wd;
   logic        m_ready = 1'b0, m_err = 1'b0;
   logic [31:0] m_rd = '0;

   function automatic bit bad_addr(input logic [31:0] addr);
      longint unsigned x;
      x = addr;
      return (x % 4 != 0) || (x < BASE) || ((x - BASE) / 4 >= DEPTH);
   endfunction

   // One request in flight; response on the edge LAT edges after accept,
   // next accept no earlier than two edges after the response edge.
   always @(posedge clk) begin
      e++;
      if (reset) begin
         pend = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_rd = '0;
         free_edge = e + 1; live = 1'b1;
      end else if (live) begin
         m_ready = 1'b0;
         if (!pend && e >= free_edge && req === 1'b1) begin
            pend = 1'b1; p_we = we; p_a = a; p_wd = wd; resp_edge = e + LAT;
         end
         if (pend && e == resp_edge) begin
            pend = 1'b0; m_ready = 1'b1; free_edge = e + 2;
            m_err = bad_addr(p_a);
            if (m_err) begin
               if (!p_we) m_rd = '0;
            end else if (p_we) begin
               mm[IW'((p_a - BASE) >> 2)] = p_wd;
            end else begin
               m_rd = mm[IW'((p_a - BASE) >> 2)];
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the LATENCY=2 instance against the model.
   always @(negedge clk) begin
      if (live && !reset) begin
         check("model_ready", {31'b0, ready}, {31'b0, m_ready});
         if (m_ready) check("model_err", {31'b0, err}, {31'b0, m_err});
         check("model_rd", rd, m_rd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input bit scramble, output int n, output logic [31:0] rd_r,
                      output logic err_r, output logic rdy_after);
      req = 1'b1; we = w; a = addr; wd = data;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      if (scramble) begin
         we = ~w; a = addr + 32'd4; wd = 32'hFFFF_FFFF;
      end
      n = 1;
      while (ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("resp_seen", {31'b0, ready}, 32'd1);
      rd_r  = rd;
      err_r = err;
      @(negedge clk);
      rdy_after = ready;
   endtask

   logic [31:0] exp_rd0  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h11, 32'h22, 32'h22};
   logic        exp_rdy0 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int n;
      logic [31:0] r;
      logic ef, ra;

      reset = 1'b1; req = 1'b0; we = 1'b0; a = '0; wd = '0;
      req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", {31'b0, ready}, 32'd0);
      check("reset_err", {31'b0, err}, 32'd0);
      check("reset_rd", rd, 32'h0);
      check("reset_ready0", {31'b0, ready0}, 32'd0);
      reset = 1'b0;

      // Zero-latency instance with req held high: accepts on alternate edges.
      req0 = 1'b1; we0 = 1'b1; a0 = 32'h40; wd0 = 32'h11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("lat0_ready", {31'b0, ready0}, {31'b0, exp_rdy0[i]});
         if (exp_rdy0[i]) check("lat0_err", {31'b0, err0}, 32'd0);
         check("lat0_rd", rd0, exp_rd0[i]);
         case (i)
            0: begin a0 = 32'h44; wd0 = 32'h22; end
            3: begin we0 = 1'b0; a0 = 32'h40; end
            4: a0 = 32'h44;
            6: req0 = 1'b0;
            default: ;
         endcase
      end

      // Preload through the port.
      txn(1'b1, 32'h0C,  32'hDEAD_BEEF, 1'b0, n, r, ef, ra);
      check("preload_err", {31'b0, ef}, 32'd0);
      txn(1'b1, 32'h3FC, 32'h5555_0000, 1'b0, n, r, ef, ra);
      txn(1'b1, 32'h20,  32'hAAAA_AAAA, 1'b0, n, r, ef, ra);
      txn(1'b1, 32'h04,  32'h0101_0101, 1'b0, n, r, ef, ra);
      txn(1'b1, 32'h08,  32'h0202_0202, 1'b0, n, r, ef, ra);

      // Read of word 3: ready in the third cycle after accept, one cycle wide.
      txn(1'b0, 32'h0C, 32'h0, 1'b0, n, r, ef, ra);
      check("rd3_latency", 32'(n), 32'd3);
      check("rd3_data", r, 32'hDEAD_BEEF);
      check("rd3_err", {31'b0, ef}, 32'd0);
      check("rd3_ready_drop", {31'b0, ra}, 32'd0);

      // Write keeps previous read data on rd_o; read-back returns new data.
      txn(1'b1, 32'h10, 32'h1234_5678, 1'b0, n, r, ef, ra);
      check("wr_keeps_rd", r, 32'hDEAD_BEEF);
      txn(1'b0, 32'h10, 32'h0, 1'b0, n, r, ef, ra);
      check("raw_data", r, 32'h1234_5678);

      // Misaligned read and out-of-range write.
      txn(1'b0, 32'h0000_0002, 32'h0, 1'b0, n, r, ef, ra);
      check("misalign_err", {31'b0, ef}, 32'd1);
      check("misalign_rd", r, 32'h0);
      txn(1'b1, DEPTH * 4, 32'hCAFE_F00D, 1'b0, n, r, ef, ra);
      check("range_err", {31'b0, ef}, 32'd1);
      txn(1'b0, (DEPTH - 1) * 4, 32'h0, 1'b0, n, r, ef, ra);
      check("last_word", r, 32'h5555_0000);
      check("last_word_err", {31'b0, ef}, 32'd0);

      // Reset during WAIT aborts a write.
      req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'hBBBB_BBBB;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_ready", {31'b0, ready}, 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      txn(1'b0, 32'h20, 32'h0, 1'b0, n, r, ef, ra);
      check("abort_kept", r, 32'hAAAA_AAAA);

      // Inputs changed after accept: captured read of word 1 is served.
      txn(1'b0, 32'h04, 32'h0, 1'b1, n, r, ef, ra);
      check("capture_rd", r, 32'h0101_0101);
      txn(1'b0, 32'h08, 32'h0, 1'b0, n, r, ef, ra);
      check("capture_word2", r, 32'h0202_0202);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
